quant_wr_arbiter: RTL and testbench

Merges the four per-row-offset write streams produced by the 4-channel requantize stream into a single write port of the shared output activation buffer. Each stream feeds a small FIFO. A round-robin arbiter drains the FIFOs at one write per cycle, gated by a buffer-ready input. Overflow is reported through sticky per-lane error bits, because the upstream quant pipeline cannot stall.

---
 rtl/quant_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_quant_wr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_wr_arbiter.sv
// Merges four per-lane requantize write streams into one buffer write port.
// Each lane has a small FIFO; a round-robin arbiter drains one entry per cycle.
module quant_wr_arbiter #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_en,
    input  logic [4*ADDR_W-1:0]   in_addr,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic                  mem_ready,
    input  logic                  err_clr,
    output logic                  mem_wr_en,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [DATA_W-1:0]     mem_wr_data,
    output logic [3:0]            almost_full,
    output logic [3:0]            ovf_err,
    output logic                  idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]        non_empty;
    logic [3:0]        grant;
    logic [3:0]        overflow;
    logic [1:0]        rr_ptr_reg;
    logic [1:0]        rr_ptr_next;
    logic [1:0]        gnt_idx;
    logic              gnt_valid;
    logic [ADDR_W-1:0] head_addr [4];
    logic [DATA_W-1:0] head_data [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
            logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;
            logic              push;
            logic              pop;

            // A full lane still accepts a push when its head leaves this cycle.
            assign pop  = grant[gi];
            assign push = in_en[gi] && ((count_reg < CNT_W'(FIFO_DEPTH)) || pop);

            assign overflow[gi]    = in_en[gi] && !push;
            assign non_empty[gi]   = (count_reg != '0);
            assign almost_full[gi] = (count_reg >= CNT_W'(FIFO_DEPTH - 1));
            assign head_addr[gi]   = addr_mem[rd_ptr_reg];
            assign head_data[gi]   = data_mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push) begin
                    addr_mem[wr_ptr_reg] <= in_addr[gi*ADDR_W +: ADDR_W];
                    data_mem[wr_ptr_reg] <= in_data[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    if (push && !pop)
                        count_reg <= count_reg + CNT_W'(1);
                    else if (pop && !push)
                        count_reg <= count_reg - CNT_W'(1);
                end
            end
        end
    endgenerate

    // Scan lanes starting at rr_ptr; the 2-bit index wraps modulo 4.
    always_comb begin
        gnt_valid   = 1'b0;
        gnt_idx     = '0;
        grant       = '0;
        rr_ptr_next = rr_ptr_reg;
        if (mem_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (!gnt_valid && non_empty[rr_ptr_reg + 2'(k)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = rr_ptr_reg + 2'(k);
                end
            end
        end
        if (gnt_valid) begin
            grant[gnt_idx] = 1'b1;
            rr_ptr_next    = gnt_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg  <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            ovf_err     <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            mem_wr_en  <= gnt_valid;
            if (gnt_valid) begin
                mem_wr_addr <= head_addr[gnt_idx];
                mem_wr_data <= head_data[gnt_idx];
            end
            // A new overflow wins over a simultaneous clear.
            ovf_err <= (err_clr ? 4'b0 : ovf_err) | overflow;
        end
    end

    assign idle = ~|non_empty && !mem_wr_en;

endmodule

// File: tb/tb_quant_wr_arbiter.sv
// Self-checking bench for quant_wr_arbiter: queue-based reference model feeding
// a write scoreboard, a vector table for single pushes, and corner-case sequences.
module tb_quant_wr_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 128;
    localparam int DEPTH = 4;
    localparam int EW    = AW + DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        in_en = '0;
    logic [4*AW-1:0]   in_addr = '0;
    logic [4*DW-1:0]   in_data = '0;
    logic              mem_ready = 1'b0;
    logic              err_clr = 1'b0;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_wr_addr;
    logic [DW-1:0]     mem_wr_data;
    logic [3:0]        almost_full;
    logic [3:0]        ovf_err;
    logic              idle;

    quant_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
        .mem_ready(mem_ready), .err_clr(err_clr), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .almost_full(almost_full), .ovf_err(ovf_err), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    // Reference model state
    logic [EW-1:0] mq [4][$];
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] sb_ent;
    int            m_rr = 0;
    logic [3:0]    m_ovf = '0;

    typedef struct {
        int          lane;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int          exp_lat;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_data(input logic [AW-1:0] a);
        return {8{a ^ 16'h5A3C}};
    endfunction

    // Apply one cycle of stimulus, advance the model, then compare after the edge.
    task automatic drive_cycle(input logic [3:0] en, input logic [4*AW-1:0] a,
                               input logic [4*DW-1:0] d, input logic rdy, input logic clr);
        int g;
        logic [3:0] dropped;
        logic [3:0] exp_af;
        logic exp_idle;
        in_en = en; in_addr = a; in_data = d; mem_ready = rdy; err_clr = clr;
        g = -1;
        if (rdy) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_rr + k) % 4;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
        end
        if (g >= 0) begin
            exp_q.push_back(mq[g].pop_front());
            m_rr = (g + 1) % 4;
        end
        dropped = '0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({a[i*AW +: AW], d[i*DW +: DW]});
                else dropped[i] = 1'b1;
            end
        end
        m_ovf = (clr ? 4'b0 : m_ovf) | dropped;
        @(posedge clk);
        #1;
        in_en = '0; err_clr = 1'b0;
        exp_af = '0;
        exp_idle = (g < 0);
        for (int i = 0; i < 4; i++) begin
            exp_af[i] = (mq[i].size() >= DEPTH - 1);
            if (mq[i].size() != 0) exp_idle = 1'b0;
        end
        check("model_wr_en", mem_wr_en, g >= 0);
        check("model_ovf_err", ovf_err, m_ovf);
        check("model_almost_full", almost_full, exp_af);
        check("model_idle", idle, exp_idle);
    endtask

    task automatic push1(input int lane, input logic [AW-1:0] addr, input logic rdy, input logic clr);
        logic [4*AW-1:0] a;
        logic [4*DW-1:0] d;
        a = '0; d = '0;
        a[lane*AW +: AW] = addr;
        d[lane*DW +: DW] = lane_data(addr);
        drive_cycle(4'(1 << lane), a, d, rdy, clr);
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive_cycle(4'b0, '0, '0, rdy, 1'b0);
    endtask

    // Scoreboard: every observed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got addr %h, required no write", mem_wr_addr);
            end else begin
                sb_ent = exp_q.pop_front();
                if ({mem_wr_addr, mem_wr_data} !== sb_ent) begin
                    errors++;
                    $display("FAIL sb_write: got %h_%h expected %h", mem_wr_addr, mem_wr_data, sb_ent);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4*AW-1:0] a;
        logic [4*DW-1:0] d;
        int lat;
        int first_ovf;
        logic [3:0] ovf_snap;
        logic [AW-1:0] first_addr;
        logic [3:0] prev_lane;
        logic [3:0] cur_lane;
        logic got_first;

        tbl[0] = '{lane: 2, addr: 16'h0010, data: {16{8'hA5}},          exp_lat: 2};
        tbl[1] = '{lane: 1, addr: 16'h1234, data: {4{32'hDEADBEEF}},    exp_lat: 2};
        tbl[2] = '{lane: 0, addr: 16'h0000, data: {8{16'h1357}},        exp_lat: 2};
        tbl[3] = '{lane: 3, addr: 16'hFFFF, data: {DW{1'b1}},           exp_lat: 2};

        // Reset values
        #12;
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_idle", idle, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-push vectors; the table order leaves rr_ptr at 0
        for (int r = 0; r < 4; r++) begin
            a = '0; d = '0;
            a[tbl[r].lane*AW +: AW] = tbl[r].addr;
            d[tbl[r].lane*DW +: DW] = tbl[r].data;
            drive_cycle(4'(1 << tbl[r].lane), a, d, 1'b1, 1'b0);
            check("single_idle_busy", idle, 1'b0);
            lat = 1;
            while (!mem_wr_en && lat < 10) begin
                idle_cycles(1, 1'b1);
                lat++;
            end
            check("single_latency", lat, tbl[r].exp_lat);
            check("single_addr", mem_wr_addr, tbl[r].addr);
            check("single_data", mem_wr_data, tbl[r].data);
            idle_cycles(1, 1'b1);
            check("single_idle_after", idle, 1'b1);
            $display("vector %0d: lane %0d addr %h latency %0d", r, tbl[r].lane, tbl[r].addr, lat);
        end

        // Four-lane burst from rr_ptr=0
        a = '0; d = '0;
        for (int i = 0; i < 4; i++) begin
            a[i*AW +: AW] = 16'(16'h0100 + i);
            d[i*DW +: DW] = lane_data(16'(16'h0100 + i));
        end
        drive_cycle(4'hF, a, d, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle_cycles(1, 1'b1);
            check("burst_wr_en", mem_wr_en, 1'b1);
            check("burst_addr", mem_wr_addr, 16'(16'h0100 + k));
        end
        idle_cycles(1, 1'b1);
        check("burst_done_idle", idle, 1'b1);
        $display("burst: 4 writes checked");

        // Overflow on lane 1 with the buffer stalled
        for (int p = 1; p <= 5; p++) begin
            push1(1, 16'(16'h0200 + p - 1), 1'b0, 1'b0);
            check("ovf_almost_full1", almost_full[1], p >= 3);
            check("ovf_err1", ovf_err[1], p >= 5);
        end
        wr_count = 0;
        got_first = 1'b0;
        first_addr = '0;
        for (int i = 0; i < 8; i++) begin
            idle_cycles(1, 1'b1);
            if (mem_wr_en && !got_first) begin
                got_first = 1'b1;
                first_addr = mem_wr_addr;
            end
        end
        check("ovf_write_count", wr_count, 4);
        check("ovf_first_addr", first_addr, 16'h0200);
        check("ovf_err_held", ovf_err, 4'b0010);
        drive_cycle(4'b0, '0, '0, 1'b1, 1'b1);
        check("ovf_err_cleared", ovf_err, 4'b0000);
        $display("overflow: lane 1 wrote %0d entries", wr_count);

        // Full lane 0: push and pop in the same cycle
        for (int p = 0; p < 4; p++) push1(0, 16'(16'h0300 + p), 1'b0, 1'b0);
        check("full_almost_full0", almost_full[0], 1'b1);
        wr_count = 0;
        push1(0, 16'h0304, 1'b1, 1'b0);
        check("full_push_no_ovf", ovf_err[0], 1'b0);
        check("full_push_wr_en", mem_wr_en, 1'b1);
        idle_cycles(1, 1'b1);
        check("full_count_kept", almost_full[0], 1'b1);
        idle_cycles(7, 1'b1);
        check("full_write_count", wr_count, 5);
        $display("full+pop+push: lane 0 wrote %0d entries", wr_count);

        // Overflow and clear in the same cycle: overflow wins
        for (int p = 0; p < 5; p++) push1(2, 16'(16'h0500 + p), 1'b0, 1'b0);
        push1(2, 16'h0505, 1'b0, 1'b1);
        check("set_wins_ovf2", ovf_err[2], 1'b1);
        drive_cycle(4'b0, '0, '0, 1'b0, 1'b1);
        check("clear_only_ovf", ovf_err, 4'b0000);
        idle_cycles(6, 1'b1);
        $display("set-wins: checked, lane 2 drained");

        // Fairness: lanes 0 and 3 push every cycle, rr_ptr starts at 3
        first_ovf = -1;
        ovf_snap = '0;
        prev_lane = '0;
        for (int c = 0; c < 20; c++) begin
            a = '0; d = '0;
            a[0*AW +: AW] = 16'(16'h0400 + c);
            a[3*AW +: AW] = 16'(16'h0C00 + c);
            d[0*DW +: DW] = lane_data(16'(16'h0400 + c));
            d[3*DW +: DW] = lane_data(16'(16'h0C00 + c));
            drive_cycle(4'b1001, a, d, 1'b1, 1'b0);
            if (first_ovf < 0 && ovf_err != 4'b0) begin
                first_ovf = c;
                ovf_snap = ovf_err;
            end
            if (c >= 1) begin
                cur_lane = mem_wr_addr[11:8];
                check("fair_wr_en", mem_wr_en, 1'b1);
                if (c == 1) check("fair_first_lane", cur_lane, 4'hC);
                else        check("fair_alternate", cur_lane != prev_lane, 1'b1);
                prev_lane = cur_lane;
            end
        end
        check("fair_first_ovf_cycle", first_ovf, 7);
        check("fair_first_ovf_lane", ovf_snap, 4'b0001);
        idle_cycles(12, 1'b1);
        $display("fairness: first overflow cycle %0d lanes %b", first_ovf, ovf_snap);

        // Reset in the middle of operation
        for (int p = 0; p < 3; p++) push1(1, 16'(16'h0600 + p), 1'b0, 1'b0);
        check("midrst_pre_af", almost_full[1], 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_rr = 0;
        m_ovf = '0;
        check("midrst_wr_en", mem_wr_en, 1'b0);
        check("midrst_wr_addr", mem_wr_addr, 0);
        check("midrst_wr_data", mem_wr_data, 0);
        check("midrst_ovf_err", ovf_err, 0);
        check("midrst_almost_full", almost_full, 0);
        check("midrst_idle", idle, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycles(6, 1'b1);
        check("midrst_idle_after", idle, 1'b1);
        $display("reset mid-operation: outputs cleared, no writes after release");

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
